// File: rtl/pong_game_ctrl.sv
// Game-level sequencer for the pong ball controller: serve, lives, BCD rally score, game over.
// All outputs registered; an input edge sampled on one clock edge is visible the following cycle.
module pong_game_ctrl #(
    parameter int LIVES           = 3,
    parameter int STEPS_PER_POINT = 40
) (
    input  logic                       i_Clk,
    input  logic                       i_Reset_n,
    input  logic                       i_Start_Btn,
    input  logic                       i_Ball_Out,
    input  logic                       i_Ball_Step,
    output logic                       o_Ball_Reset,
    output logic                       o_Ball_Ready,
    output logic [$clog2(LIVES+1)-1:0] o_Lives,
    output logic [3:0]                 o_Score_Tens,
    output logic [3:0]                 o_Score_Ones,
    output logic                       o_Playing,
    output logic                       o_Game_Over
);

    localparam int LW = $clog2(LIVES + 1);
    localparam int SW = $clog2(STEPS_PER_POINT + 1);
    localparam logic [LW-1:0] LIVES_INIT = LW'(LIVES);
    localparam logic [SW-1:0] STEP_LAST  = SW'(STEPS_PER_POINT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_PLAY = 2'd2,
        S_OVER = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic            start_prev, out_prev, step_prev;
    logic            start_evt, out_evt, step_evt;
    logic [SW-1:0]   step_cnt, step_cnt_nxt;
    logic [LW-1:0]   lives_nxt;
    logic [3:0]      tens_nxt, ones_nxt;

    assign start_evt = i_Start_Btn & ~start_prev;
    assign out_evt   = i_Ball_Out  & ~out_prev;
    assign step_evt  = i_Ball_Step & ~step_prev;

    always_comb begin
        state_nxt    = state;
        lives_nxt    = o_Lives;
        tens_nxt     = o_Score_Tens;
        ones_nxt     = o_Score_Ones;
        step_cnt_nxt = step_cnt;
        case (state)
            S_IDLE: begin
                lives_nxt    = LIVES_INIT;
                tens_nxt     = 4'd0;
                ones_nxt     = 4'd0;
                step_cnt_nxt = '0;
                if (start_evt) state_nxt = S_ARM;
            end
            S_ARM: begin
                state_nxt = S_PLAY;
            end
            S_PLAY: begin
                // A miss outranks a simultaneous step: the rally that just ended earns nothing.
                if (out_evt) begin
                    step_cnt_nxt = '0;
                    if (o_Lives == LW'(1)) begin
                        lives_nxt = '0;
                        state_nxt = S_OVER;
                    end else begin
                        lives_nxt = o_Lives - LW'(1);
                    end
                end else if (step_evt) begin
                    if (step_cnt == STEP_LAST) begin
                        step_cnt_nxt = '0;
                        if (!(o_Score_Tens == 4'd9 && o_Score_Ones == 4'd9)) begin
                            if (o_Score_Ones == 4'd9) begin
                                ones_nxt = 4'd0;
                                tens_nxt = o_Score_Tens + 4'd1;
                            end else begin
                                ones_nxt = o_Score_Ones + 4'd1;
                            end
                        end
                    end else begin
                        step_cnt_nxt = step_cnt + SW'(1);
                    end
                end
            end
            S_OVER: begin
                if (start_evt) begin
                    state_nxt    = S_ARM;
                    lives_nxt    = LIVES_INIT;
                    tens_nxt     = 4'd0;
                    ones_nxt     = 4'd0;
                    step_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            state        <= S_IDLE;
            start_prev   <= 1'b1;
            out_prev     <= 1'b1;
            step_prev    <= 1'b1;
            step_cnt     <= '0;
            o_Lives      <= LIVES_INIT;
            o_Score_Tens <= 4'd0;
            o_Score_Ones <= 4'd0;
            o_Ball_Reset <= 1'b1;
            o_Ball_Ready <= 1'b0;
            o_Playing    <= 1'b0;
            o_Game_Over  <= 1'b0;
        end else begin
            state        <= state_nxt;
            start_prev   <= i_Start_Btn;
            out_prev     <= i_Ball_Out;
            step_prev    <= i_Ball_Step;
            step_cnt     <= step_cnt_nxt;
            o_Lives      <= lives_nxt;
            o_Score_Tens <= tens_nxt;
            o_Score_Ones <= ones_nxt;
            o_Ball_Reset <= (state_nxt == S_IDLE) || (state_nxt == S_OVER);
            o_Ball_Ready <= (state_nxt == S_ARM);
            o_Playing    <= (state_nxt == S_PLAY);
            o_Game_Over  <= (state_nxt == S_OVER);
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl (LIVES=3, STEPS_PER_POINT=40): vector table plus scoring/collision sequences.
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, start, out, step;
    logic       ball_reset, ball_ready, playing, game_over;
    logic [1:0] lives;
    logic [3:0] tens, ones;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pong_game_ctrl #(.LIVES(3), .STEPS_PER_POINT(40)) dut (
        .i_Clk        (clk),
        .i_Reset_n    (rst_n),
        .i_Start_Btn  (start),
        .i_Ball_Out   (out),
        .i_Ball_Step  (step),
        .o_Ball_Reset (ball_reset),
        .o_Ball_Ready (ball_ready),
        .o_Lives      (lives),
        .o_Score_Tens (tens),
        .o_Score_Ones (ones),
        .o_Playing    (playing),
        .o_Game_Over  (game_over)
    );

    typedef struct {
        logic       rst_n, start, out, step;
        logic       br, rdy;
        logic [1:0] lives;
        logic [3:0] tens, ones;
        logic       play, over;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(logic r, logic s, logic o, logic st, logic br, logic rdy,
                                logic [1:0] lv, logic [3:0] t, logic [3:0] on, logic pl, logic ov);
        vec_t v;
        v.rst_n = r; v.start = s; v.out = o; v.step = st;
        v.br = br; v.rdy = rdy; v.lives = lv; v.tens = t; v.ones = on; v.play = pl; v.over = ov;
        return v;
    endfunction

    function automatic logic [14:0] snap();
        return {ball_reset, ball_ready, lives, tens, ones, playing, game_over};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_steps(input int n);
        for (int k = 0; k < n; k++) begin
            step = 1'b1; cyc();
            step = 1'b0; cyc();
        end
    endtask

    task automatic pulse_out();
        out = 1'b1; cyc();
        out = 1'b0; cyc();
    endtask

    initial begin
        //               rst st out stp  br rdy lv  tens ones pl ov
        vecs[0]  = mk(0, 0, 0, 0,  1, 0, 3, 0, 0, 0, 0);  // reset
        vecs[1]  = mk(0, 0, 0, 0,  1, 0, 3, 0, 0, 0, 0);
        vecs[2]  = mk(1, 0, 0, 0,  1, 0, 3, 0, 0, 0, 0);  // idle
        vecs[3]  = mk(1, 1, 0, 0,  0, 1, 3, 0, 0, 0, 0);  // start edge -> ARM
        vecs[4]  = mk(1, 1, 0, 0,  0, 0, 3, 0, 0, 1, 0);  // PLAY
        vecs[5]  = mk(1, 0, 0, 0,  0, 0, 3, 0, 0, 1, 0);
        vecs[6]  = mk(1, 1, 0, 0,  0, 0, 3, 0, 0, 1, 0);  // start ignored in PLAY
        vecs[7]  = mk(1, 0, 1, 0,  0, 0, 2, 0, 0, 1, 0);  // miss 1
        vecs[8]  = mk(1, 0, 0, 0,  0, 0, 2, 0, 0, 1, 0);
        vecs[9]  = mk(1, 0, 1, 0,  0, 0, 1, 0, 0, 1, 0);  // miss 2
        vecs[10] = mk(1, 0, 0, 0,  0, 0, 1, 0, 0, 1, 0);
        vecs[11] = mk(1, 0, 1, 0,  1, 0, 0, 0, 0, 0, 1);  // miss 3 -> OVER
        vecs[12] = mk(1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1);
        vecs[13] = mk(1, 1, 0, 0,  0, 1, 3, 0, 0, 0, 0);  // start in OVER -> ARM
        vecs[14] = mk(1, 0, 0, 0,  0, 0, 3, 0, 0, 1, 0);
        vecs[15] = mk(0, 0, 0, 0,  1, 0, 3, 0, 0, 0, 0);  // reset mid-PLAY
        vecs[16] = mk(0, 1, 0, 0,  1, 0, 3, 0, 0, 0, 0);  // start held through reset
        vecs[17] = mk(1, 1, 0, 0,  1, 0, 3, 0, 0, 0, 0);  // no edge after reset
        vecs[18] = mk(1, 0, 0, 0,  1, 0, 3, 0, 0, 0, 0);
        vecs[19] = mk(1, 1, 0, 0,  0, 1, 3, 0, 0, 0, 0);  // ARM
        vecs[20] = mk(0, 0, 0, 0,  1, 0, 3, 0, 0, 0, 0);  // reset during ARM drops Ready
        vecs[21] = mk(1, 0, 1, 0,  1, 0, 3, 0, 0, 0, 0);  // miss ignored in IDLE
        vecs[22] = mk(1, 0, 0, 1,  1, 0, 3, 0, 0, 0, 0);  // step ignored in IDLE

        rst_n = 1'b0; start = 1'b0; out = 1'b0; step = 1'b0;
        #1;
        for (int i = 0; i < 23; i++) begin
            rst_n = vecs[i].rst_n; start = vecs[i].start;
            out = vecs[i].out; step = vecs[i].step;
            cyc();
            chk($sformatf("vec%0d", i), 32'(snap()),
                32'({vecs[i].br, vecs[i].rdy, vecs[i].lives, vecs[i].tens, vecs[i].ones,
                     vecs[i].play, vecs[i].over}));
        end

        // Fresh serve from IDLE
        out = 1'b0; step = 1'b0; start = 1'b0; cyc();
        start = 1'b1; cyc();
        chk("serve_ready", {31'd0, ball_ready}, 32'd1);
        chk("serve_ballrst", {31'd0, ball_reset}, 32'd0);
        start = 1'b0; cyc();
        chk("serve_ready_drop", {31'd0, ball_ready}, 32'd0);
        chk("serve_playing", {31'd0, playing}, 32'd1);

        // Collision at step_cnt=39: miss wins, counter cleared, no point
        pulse_steps(39);
        chk("score_39", {24'd0, tens, ones}, 32'h00);
        out = 1'b1; step = 1'b1; cyc();
        out = 1'b0; step = 1'b0; cyc();
        chk("coll_lives", {30'd0, lives}, 32'd2);
        chk("coll_score", {24'd0, tens, ones}, 32'h00);
        pulse_steps(1);
        chk("coll_cnt_cleared", {24'd0, tens, ones}, 32'h00);

        // Scoring, counted from the collision
        pulse_steps(39);
        chk("score_40", {24'd0, tens, ones}, 32'h01);
        pulse_steps(360);
        chk("score_400", {24'd0, tens, ones}, 32'h10);
        pulse_steps(3559);
        chk("score_3959", {24'd0, tens, ones}, 32'h98);
        pulse_steps(1);
        chk("score_3960", {24'd0, tens, ones}, 32'h99);
        pulse_steps(40);
        chk("score_4000", {24'd0, tens, ones}, 32'h99);
        pulse_steps(40);
        chk("score_4040", {24'd0, tens, ones}, 32'h99);

        // Remaining lives: 2 -> 1 -> 0
        pulse_out();
        chk("miss_lives1", {30'd0, lives}, 32'd1);
        chk("miss_playing", {31'd0, playing}, 32'd1);
        pulse_out();
        chk("over_lives", {30'd0, lives}, 32'd0);
        chk("over_flag", {31'd0, game_over}, 32'd1);
        chk("over_ballrst", {31'd0, ball_reset}, 32'd1);
        chk("over_score_held", {24'd0, tens, ones}, 32'h99);
        pulse_steps(2);
        chk("over_steps_ignored", {24'd0, tens, ones}, 32'h99);

        // Restart from OVER
        start = 1'b1; cyc();
        chk("restart", 32'(snap()), 32'({1'b0, 1'b1, 2'd3, 4'd0, 4'd0, 1'b0, 1'b0}));
        start = 1'b0; cyc();
        chk("restart_play", 32'(snap()), 32'({1'b0, 1'b0, 2'd3, 4'd0, 4'd0, 1'b1, 1'b0}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
